// File: rtl/gf227_pkg.sv
// Shared GF(227) constants and a reference Barrett reduction used by the
// field-arithmetic blocks.
package gf227_pkg;

  localparam int GF_Q  = 227;   // field modulus
  localparam int GF_MU = 288;   // floor(2^16 / GF_Q)
  localparam int EW    = 8;     // element width
  localparam int PW    = 16;    // product width
  localparam int RW    = 10;    // uncorrected residue width, holds < 3*Q

  // Full Barrett reduction of a 16-bit product, returning the true residue.
  // The quotient estimate is low by at most two, so two conditional
  // subtractions always land in [0, Q).
  function automatic logic [EW-1:0] barrett_reduce16(input logic [PW-1:0] p);
    logic [PW-1:0] t;
    logic [RW-1:0] r;
    t = PW'((24'(p[15:8]) * 24'(GF_MU)) >> 8);
    r = RW'(p - PW'(t * PW'(GF_Q)));
    if (r >= RW'(GF_Q)) r = r - RW'(GF_Q);
    if (r >= RW'(GF_Q)) r = r - RW'(GF_Q);
    return EW'(r);
  endfunction

endpackage

// File: rtl/gf227_mulred_sched_if.sv
// Request/response bundle between the field-arithmetic clients and the
// shared multiply-reduce unit.
//
// Handshake: a request from requester i transfers on a rising edge where
// req_valid[i] & req_ready[i]; a response transfers where
// rsp_valid & rsp_ready. A requester holds req_a/req_b stable while its
// valid is high and ready is low (it may drop valid before the grant);
// the unit holds rsp_data/rsp_id stable while rsp_valid & !rsp_ready.
interface gf227_mulred_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/gf227_barrett_pipe.sv
// Three-stage multiply + Barrett reduce datapath with valid/id sideband.
// Never stalls: the caller only issues when downstream space is reserved.
module gf227_barrett_pipe
  import gf227_pkg::*;
#(
  parameter int Q   = GF_Q,
  parameter int MU  = GF_MU,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [EW-1:0]  in_a,
  input  logic [EW-1:0]  in_b,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  output logic [EW-1:0]  out_data,
  output logic [IDW-1:0] out_id
);

  logic           v1, v2, v3;
  logic [IDW-1:0] id1, id2, id3;
  logic [PW-1:0]  p1, p2, t2;
  logic [RW-1:0]  r3, c1, c2;

  // Stage registers: S1 product, S2 quotient estimate, S3 raw remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      id1 <= '0;
      id2 <= '0;
      id3 <= '0;
      p1  <= '0;
      p2  <= '0;
      t2  <= '0;
      r3  <= '0;
    end else begin
      v1  <= in_valid;
      id1 <= in_id;
      p1  <= PW'(in_a) * PW'(in_b);
      v2  <= v1;
      id2 <= id1;
      p2  <= p1;
      t2  <= PW'((24'(p1[15:8]) * 24'(MU)) >> 8);
      v3  <= v2;
      id3 <= id2;
      r3  <= RW'(p2 - PW'(t2 * PW'(Q)));
    end
  end

  // Bring the S3 remainder from [0, 3Q) into [0, Q) with two conditional subtracts.
  always_comb begin
    c1 = (r3 >= RW'(Q)) ? r3 - RW'(Q) : r3;
    c2 = (c1 >= RW'(Q)) ? c1 - RW'(Q) : c1;
  end

  assign out_valid = v3;
  assign out_id    = id3;
  assign out_data  = EW'(c2);

endmodule

// File: rtl/gf227_mulred_sched.sv
// Round-robin shared GF(227) multiply-reduce unit. Credit-gated arbitration
// feeds a non-stalling pipeline whose results queue in a small response FIFO.
module gf227_mulred_sched
  import gf227_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int Q      = GF_Q,
  parameter int MU     = GF_MU,
  parameter int FDEPTH = 4,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gf227_mulred_sched_if.slave  bus,
  output logic                 busy,
  output logic [IDW-1:0]       rr_ptr
);

  localparam int AW   = $clog2(FDEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(FDEPTH + 1);

  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            credit_ok;
  logic            xfer;
  logic            pop;
  logic            push;
  logic            full;
  logic            empty;
  logic [CW-1:0]   inflight;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            pipe_valid;
  logic [EW-1:0]   pipe_data;
  logic [IDW-1:0]  pipe_id;
  logic [EW-1:0]   mem_data [FDEPTH];
  logic [IDW-1:0]  mem_id   [FDEPTH];

  assign empty = (count == '0);
  assign full  = (count == CNTW'(FDEPTH));
  assign pop   = !empty && bus.rsp_ready;
  assign push  = pipe_valid;

  // A pop in this cycle frees a slot that the grant in this cycle may use.
  assign credit_ok = (inflight < CW'(FDEPTH)) || pop;
  assign xfer      = grant_any && credit_ok;

  // Round-robin pick: first valid requester at or after rr, wrapping.
  always_comb begin
    grant_any     = 1'b0;
    grant_idx     = '0;
    bus.req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && bus.req_valid[(int'(rr) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IDW'((int'(rr) + k) % NREQ);
      end
    end
    if (grant_any && credit_ok) bus.req_ready[grant_idx] = 1'b1;
  end

  // Pointer moves past the winner only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (xfer) begin
      rr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Ops owned by the unit: pipeline stages plus FIFO occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(xfer) - CW'(pop);
    end
  end

  gf227_barrett_pipe #(
    .Q   (Q),
    .MU  (MU),
    .IDW (IDW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (xfer),
    .in_a      (bus.req_a[grant_idx*8 +: 8]),
    .in_b      (bus.req_b[grant_idx*8 +: 8]),
    .in_id     (grant_idx),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_id    (pipe_id)
  );

  // FIFO pointers and occupancy; reset discards any queued responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  // FIFO storage; contents are only observable through the occupancy gate.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= pipe_data;
      mem_id[wr_ptr]   <= pipe_id;
    end
  end

  // Credit accounting guarantees a free slot for every pipeline result.
  always @(posedge clk) begin
    if (rst_n) begin
      fifo_no_overflow: assert (!(push && full));
    end
  end

  assign bus.rsp_valid = !empty;
  assign bus.rsp_data  = empty ? '0 : mem_data[rd_ptr];
  assign bus.rsp_id    = empty ? '0 : mem_id[rd_ptr];
  assign busy          = (inflight != '0);
  assign rr_ptr        = rr;

endmodule

// File: tb/tb_gf227_mulred_sched.sv
// Directed and randomized checks for the shared GF(227) multiply-reduce unit.
module tb_gf227_mulred_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           busy;
  logic [IDW-1:0] rr_ptr;

  gf227_mulred_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  gf227_mulred_sched #(
    .NREQ   (NREQ),
    .Q      (227),
    .MU     (288),
    .FDEPTH (4),
    .IDW    (IDW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .rr_ptr (rr_ptr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [9:0]    exp_q[$];
  logic [3:0]    vld;
  logic [7:0]    op_a [NREQ];
  logic [7:0]    op_b [NREQ];
  bit            obs_grant, obs_pop;
  int            obs_gidx;
  int            rsp_count [NREQ];
  bit            hold_pend;
  logic [10:0]   hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Driver: push shadow requester state onto the bus.
  task automatic apply();
    bus.req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*8 +: 8] = op_a[i];
      bus.req_b[i*8 +: 8] = op_b[i];
    end
  endtask

  task automatic refresh(input int i);
    op_a[i] = 8'($urandom_range(0, 255));
    op_b[i] = 8'($urandom_range(0, 255));
  endtask

  // One clock: called at posedge+1, observes at the falling edge, returns at posedge+1.
  task automatic cycle();
    logic [9:0] e;
    apply();
    #4;
    obs_grant = 1'b0;
    obs_pop   = 1'b0;
    chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    chk("ready_subset", 32'((bus.req_ready & ~bus.req_valid) == '0), 1);
    if (hold_pend) chk("rsp_stable", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, hold_val);
    if ((bus.req_valid & bus.req_ready) != '0) begin
      obs_grant = 1'b1;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) obs_gidx = i;
      e[9:8] = 2'(obs_gidx);
      e[7:0] = 8'((32'(op_a[obs_gidx]) * 32'(op_b[obs_gidx])) % 227);
      exp_q.push_back(e);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      obs_pop = 1'b1;
      chk("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", bus.rsp_data, e[7:0]);
        chk("rsp_id", bus.rsp_id, e[9:8]);
        rsp_count[int'(e[9:8])]++;
      end
    end
    hold_pend = bus.rsp_valid && !bus.rsp_ready;
    hold_val  = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    vld = '0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", busy, 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    vld = '0;
    apply();
    exp_q.delete();
    hold_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Lone request: checks grant, rr advance, N+3 latency and result.
  task automatic single_op(input int id, input int a, input int b, input int exp_d);
    hold_pend = 1'b0;
    bus.rsp_ready = 1'b1;
    vld = '0;
    vld[id] = 1'b1;
    op_a[id] = 8'(a);
    op_b[id] = 8'(b);
    apply();
    #4;
    chk("sop_ready", bus.req_ready, 32'(1) << id);
    @(posedge clk);  // edge N
    #1;
    vld = '0;
    apply();
    chk("sop_rr", rr_ptr, (id + 1) % NREQ);
    chk("sop_busy", busy, 1);
    @(posedge clk);
    #1;
    @(posedge clk);  // edge N+2
    #1;
    chk("sop_early", bus.rsp_valid, 0);
    @(posedge clk);  // edge N+3
    #1;
    chk("sop_valid", bus.rsp_valid, 1);
    chk("sop_data", bus.rsp_data, exp_d);
    chk("sop_id", bus.rsp_id, id);
    @(posedge clk);
    #1;
    chk("sop_popped", bus.rsp_valid, 0);
    chk("sop_idle", busy, 0);
  endtask

  initial begin
    int n, g, pops, sent;
    int glog[$];

    // Reset state
    rst_n = 1'b0;
    vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      rsp_count[i] = 0;
    end
    hold_pend = 1'b0;
    bus.rsp_ready = 1'b0;
    apply();
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rr", rr_ptr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single op and boundary operands
    single_op(2, 226, 226, 1);
    single_op(0, 255, 255, 103);
    single_op(1, 0, 200, 0);
    single_op(3, 100, 3, 73);
    single_op(2, 227, 1, 0);

    // Fairness: all requesters valid for 12 grants
    reset_pulse();
    for (int i = 0; i < NREQ; i++) begin
      refresh(i);
      rsp_count[i] = 0;
    end
    vld = 4'hF;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (glog.size() < 12 && n < 100) begin
      cycle();
      n++;
      if (obs_grant) begin
        glog.push_back(obs_gidx);
        refresh(obs_gidx);
      end
    end
    chk("fair_grants", glog.size(), 12);
    chk("fair_cycles", n, 12);
    for (int k = 0; k < glog.size(); k++) chk("fair_order", glog[k], k % NREQ);
    drain(30);
    for (int i = 0; i < NREQ; i++) chk("fair_rsp_count", rsp_count[i], 3);

    // Backpressure: at most FDEPTH accepted, grant resumes on first pop
    hold_pend = 1'b0;
    vld = 4'hF;
    bus.rsp_ready = 1'b0;
    g = 0;
    repeat (10) begin
      cycle();
      if (obs_grant) begin
        g++;
        refresh(obs_gidx);
      end
    end
    chk("bp_grants", g, 4);
    apply();
    #1;
    chk("bp_ready_low", bus.req_ready, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    cycle();
    chk("bp_pop_and_grant", {obs_pop, obs_grant}, 2'b11);
    drain(30);

    // Reset with three ops in flight
    hold_pend = 1'b0;
    vld = 4'b0111;
    for (int i = 0; i < NREQ; i++) refresh(i);
    g = 0;
    repeat (3) begin
      cycle();
      if (obs_grant) g++;
    end
    chk("rst_mid_grants", g, 3);
    vld = '0;
    apply();
    chk("rst_mid_busy_before", busy, 1);
    chk("rst_mid_rr_before", rr_ptr, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rr", rr_ptr, 0);
    exp_q.delete();
    hold_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pops = 0;
    repeat (10) begin
      cycle();
      if (obs_pop) pops++;
    end
    chk("rst_mid_no_stale", pops, 0);

    // Random soak with random response backpressure
    sent = 0;
    n = 0;
    while (sent < 10000 && n < 60000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          vld[i] = 1'b1;
          refresh(i);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
      if (obs_grant) begin
        vld[obs_gidx] = 1'b0;
        sent++;
      end
    end
    chk("soak_sent", sent, 10000);
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
